// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: shared FSM encoding, field indices and default CRC settings for cmd_frame_rx
package cmd_frame_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int IDX_CMD = 0;
  localparam int IDX_ARG1 = 1;
  localparam int IDX_ARG2 = 2;
  localparam logic [7:0] CRC8_POLY_DEF = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEF = 8'h00;
  localparam logic [15:0] CRC16_POLY_DEF = 16'h1021;
  localparam logic [15:0] CRC16_INIT_DEF = 16'hFFFF;
endpackage

// File: rtl/crc_bitserial.sv
// crc_bitserial: MSB-first bit-serial CRC register; clk/rst_n, init reloads INIT, en shifts bit_in in, crc is the running value
module crc_bitserial #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = '0,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= INIT;
    else if (init) crc <= INIT;
    else if (en) crc <= {crc[WIDTH-2:0], 1'b0} ^ ((crc[WIDTH-1] ^ bit_in) ? POLY : '0);
endmodule

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: command frame assembler; byte_valid/byte_in/byte_ready stream in, cmd_reset/crc_reset/cmd_en/crc_en controls, byte_finished/frame_finished pulses, cmd/arg1/arg2 fields, checksum_crc8/checksum_crc16 out; CMD_FRAME_RX_TIMEOUT_EN adds timeout_pulse
module cmd_frame_rx import cmd_frame_pkg::*; #(
  parameter int FRAME_LEN = 3,
  parameter logic [7:0] CRC8_POLY = CRC8_POLY_DEF,
  parameter logic [7:0] CRC8_INIT = CRC8_INIT_DEF,
  parameter logic [15:0] CRC16_POLY = CRC16_POLY_DEF,
  parameter logic [15:0] CRC16_INIT = CRC16_INIT_DEF
`ifdef CMD_FRAME_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        byte_ready,
  input  logic        cmd_reset,
  input  logic        crc_reset,
  input  logic        cmd_en,
  input  logic        crc_en,
  output logic        byte_finished,
  output logic        frame_finished,
  output logic [7:0]  cmd,
  output logic [7:0]  arg1,
  output logic [7:0]  arg2,
  output logic [7:0]  checksum_crc8,
  output logic [15:0] checksum_crc16
`ifdef CMD_FRAME_RX_TIMEOUT_EN
  , output logic      timeout_pulse
`endif
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
  state_t state, state_d;
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic ce_q, re_q, accept, timeout, crc_init, crc_step;
  logic [IW-1:0] idx;
  assign byte_ready = rst_n && state == IDLE && !cmd_reset && !crc_reset;
  assign accept = byte_valid && byte_ready;
  assign crc_init = crc_reset || timeout;
  assign crc_step = state == SHIFT && re_q && !cmd_reset;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    byte_finished = 1'b0;
    frame_finished = 1'b0;
    unique case (state)
      IDLE: state_d = accept ? SHIFT : IDLE;
      SHIFT: state_d = (cmd_reset || crc_reset) ? IDLE : (bit_cnt == 3'd7 ? DONE : SHIFT);
      DONE: begin
        state_d = IDLE;
        byte_finished = !cmd_reset;
        frame_finished = !cmd_reset && ce_q && idx == LAST;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      bit_cnt <= '0;
      ce_q <= 1'b0;
      re_q <= 1'b0;
      idx <= '0;
      cmd <= '0;
      arg1 <= '0;
      arg2 <= '0;
    end else begin
      if (accept) begin
        sh <= byte_in;
        bit_cnt <= '0;
        ce_q <= cmd_en;
        re_q <= crc_en;
      end else if (state == SHIFT) begin
        sh <= {sh[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (cmd_reset) begin
        idx <= '0;
        cmd <= '0;
        arg1 <= '0;
        arg2 <= '0;
      end else if (timeout) idx <= '0;
      else if (accept && cmd_en) begin
        cmd <= idx == IW'(IDX_CMD) ? byte_in : cmd;
        arg1 <= idx == IW'(IDX_ARG1) ? byte_in : arg1;
        arg2 <= idx == IW'(IDX_ARG2) ? byte_in : arg2;
      end else if (byte_finished && ce_q) idx <= idx == LAST ? '0 : idx + 1'b1;
    end
`ifdef CMD_FRAME_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic counting;
  // only idle time inside a partially received frame counts toward the timeout
  assign counting = state == IDLE && idx != '0 && !accept && !cmd_reset;
  assign timeout = counting && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign timeout_pulse = timeout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_cnt <= '0;
    else to_cnt <= (!counting || timeout) ? '0 : to_cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  crc_bitserial #(.WIDTH(8), .POLY(CRC8_POLY), .INIT(CRC8_INIT)) u_crc8 (
    .clk(clk), .rst_n(rst_n), .init(crc_init), .en(crc_step), .bit_in(sh[7]), .crc(checksum_crc8)
  );
  crc_bitserial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk(clk), .rst_n(rst_n), .init(crc_init), .en(crc_step), .bit_in(sh[7]), .crc(checksum_crc16)
  );
endmodule

// File: tb/tb_cmd_frame_rx.sv
// tb_cmd_frame_rx: table-driven and randomized checks of cmd_frame_rx against a byte-level reference model
module tb_cmd_frame_rx;
  logic clk = 1'b0, rst_n = 1'b0, byte_valid = 1'b0, cmd_reset = 1'b0, crc_reset = 1'b0;
  logic cmd_en = 1'b0, crc_en = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic byte_ready, byte_finished, frame_finished;
  logic [7:0] cmd, arg1, arg2, crc8;
  logic [15:0] crc16;
  logic r9, bf9, ff9;
  logic [7:0] cmd9, a19, a29, crc8_9;
  logic [15:0] crc16_9;
`ifdef CMD_FRAME_RX_TIMEOUT_EN
  logic to_p, to_p9;
`endif
  always #5 clk = ~clk;

  cmd_frame_rx #(.FRAME_LEN(3)
`ifdef CMD_FRAME_RX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready),
    .cmd_reset(cmd_reset), .crc_reset(crc_reset), .cmd_en(cmd_en), .crc_en(crc_en),
    .byte_finished(byte_finished), .frame_finished(frame_finished), .cmd(cmd), .arg1(arg1), .arg2(arg2),
    .checksum_crc8(crc8), .checksum_crc16(crc16)
`ifdef CMD_FRAME_RX_TIMEOUT_EN
    , .timeout_pulse(to_p)
`endif
  );

  cmd_frame_rx #(.FRAME_LEN(9)
`ifdef CMD_FRAME_RX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut9 (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(r9),
    .cmd_reset(cmd_reset), .crc_reset(crc_reset), .cmd_en(cmd_en), .crc_en(crc_en),
    .byte_finished(bf9), .frame_finished(ff9), .cmd(cmd9), .arg1(a19), .arg2(a29),
    .checksum_crc8(crc8_9), .checksum_crc16(crc16_9)
`ifdef CMD_FRAME_RX_TIMEOUT_EN
    , .timeout_pulse(to_p9)
`endif
  );

  int n_cmp = 0, n_fail = 0;
  logic [7:0] m_fld [3];
  int m_idx;
  logic [7:0] m_c8;
  logic [15:0] m_c16;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
    c = c ^ b;
    repeat (8) c = c[7] ? {c[6:0], 1'b0} ^ 8'h07 : {c[6:0], 1'b0};
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    c = c ^ {b, 8'h00};
    repeat (8) c = c[15] ? {c[14:0], 1'b0} ^ 16'h1021 : {c[14:0], 1'b0};
    return c;
  endfunction

  function automatic logic model_byte(input logic [7:0] b, input logic ce, input logic re);
    logic ff;
    ff = ce && m_idx == 2;
    if (ce) begin
      m_fld[m_idx] = b;
      m_idx = (m_idx + 1) % 3;
    end
    if (re) begin
      m_c8 = crc8_byte(m_c8, b);
      m_c16 = crc16_byte(m_c16, b);
    end
    return ff;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_resets(input logic cr, input logic rr);
    cmd_reset = cr;
    crc_reset = rr;
    tick();
    cmd_reset = 1'b0;
    crc_reset = 1'b0;
    #1;
    if (cr) begin
      m_idx = 0;
      foreach (m_fld[i]) m_fld[i] = 8'h00;
    end
    if (rr) begin
      m_c8 = 8'h00;
      m_c16 = 16'hFFFF;
    end
  endtask

  // returns in the byte_finished cycle; lat counts cycles from the accept cycle
  task automatic do_byte(input logic [7:0] b, input logic ce, input logic re,
                         output int lat, output logic ff, output logic f9, output logic eff);
    int n;
    byte_valid = 1'b1;
    byte_in = b;
    cmd_en = ce;
    crc_en = re;
    #1;
    n = 0;
    while (!byte_ready && n < 30) begin
      tick();
      n++;
    end
    tick();
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
    cmd_en = 1'($urandom);
    crc_en = 1'($urandom);
    eff = model_byte(b, ce, re);
    lat = 1;
    while (!byte_finished && lat < 30) begin
      tick();
      lat++;
    end
    ff = frame_finished;
    f9 = ff9;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'(m_fld[0]));
    chk({tag, "_arg1"}, 32'(arg1), 32'(m_fld[1]));
    chk({tag, "_arg2"}, 32'(arg2), 32'(m_fld[2]));
    chk({tag, "_crc8"}, 32'(crc8), 32'(m_c8));
    chk({tag, "_crc16"}, 32'(crc16), 32'(m_c16));
  endtask

  typedef struct {
    logic pre_crc;
    logic [7:0] b;
    logic ce, re;
    logic [7:0] e_cmd, e_a1, e_a2, e_c8;
    logic chk16;
    logic [15:0] e_c16;
    logic e_ff;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int lat, k, last, nbf, cnt9;
    logic ff, f9, eff, ce, re;
    logic [7:0] b;
    logic [7:0] seq [5];
    string s;
    tbl[0] = '{1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h07, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 8'h02, 1'b1, 1'b1, 8'h01, 8'h02, 8'h00, 8'h1B, 1'b0, 16'h0000, 1'b0};
    tbl[2] = '{1'b0, 8'h03, 1'b1, 1'b1, 8'h01, 8'h02, 8'h03, 8'h48, 1'b1, 16'hADAD, 1'b1};
    tbl[3] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 8'h02, 8'h03, 8'h07, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 8'h07, 1'b0, 16'h0000, 1'b0};
    tbl[5] = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 8'h02, 8'h03, 8'h07, 1'b0, 16'h0000, 1'b0};
    m_idx = 0;
    foreach (m_fld[i]) m_fld[i] = 8'h00;
    m_c8 = 8'h00;
    m_c16 = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_bf", 32'(byte_finished), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_crc8", 32'(crc8), 0);
    chk("rst_crc16", 32'(crc16), 32'hFFFF);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 32'(byte_ready), 1);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].pre_crc) do_resets(1'b0, 1'b1);
      do_byte(tbl[i].b, tbl[i].ce, tbl[i].re, lat, ff, f9, eff);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 9);
      chk($sformatf("tbl%0d_ff", i), 32'(ff), 32'(tbl[i].e_ff));
      chk($sformatf("tbl%0d_cmd", i), 32'(cmd), 32'(tbl[i].e_cmd));
      chk($sformatf("tbl%0d_arg1", i), 32'(arg1), 32'(tbl[i].e_a1));
      chk($sformatf("tbl%0d_arg2", i), 32'(arg2), 32'(tbl[i].e_a2));
      chk($sformatf("tbl%0d_crc8", i), 32'(crc8), 32'(tbl[i].e_c8));
      if (tbl[i].chk16) chk($sformatf("tbl%0d_crc16", i), 32'(crc16), 32'(tbl[i].e_c16));
      tick();
      chk($sformatf("tbl%0d_ready_after", i), 32'(byte_ready), 1);
    end

    do_resets(1'b1, 1'b1);
    s = "123456789";
    cnt9 = 0;
    for (int i = 0; i < 9; i++) begin
      do_byte(s[i], 1'b1, 1'b1, lat, ff, f9, eff);
      if (f9) cnt9++;
      if (i == 8) chk("ascii_ff9_last", 32'(f9), 1);
      tick();
    end
    chk("ascii_ff9_count", 32'(cnt9), 1);
    chk("ascii_crc8", 32'(crc8_9), 32'hF4);
    chk("ascii_crc16", 32'(crc16_9), 32'h29B1);
    chk_model("ascii3");

    do_resets(1'b1, 1'b0);
    do_byte(8'h3C, 1'b1, 1'b1, lat, ff, f9, eff);
    chk("cr_pre_cmd", 32'(cmd), 32'h3C);
    tick();
    byte_valid = 1'b1;
    byte_in = 8'h55;
    cmd_en = 1'b1;
    crc_en = 1'b1;
    #1;
    chk("cr_ready", 32'(byte_ready), 1);
    tick();
    byte_valid = 1'b0;
    chk("cr_arg1_at_accept", 32'(arg1), 32'h55);
    repeat (3) tick();
    cmd_reset = 1'b1;
    #1;
    nbf = int'(byte_finished);
    tick();
    cmd_reset = 1'b0;
    #1;
    chk("cr_ready_next", 32'(byte_ready), 1);
    chk("cr_cmd", 32'(cmd), 0);
    chk("cr_arg1", 32'(arg1), 0);
    chk("cr_arg2", 32'(arg2), 0);
    repeat (12) begin
      nbf += int'(byte_finished);
      tick();
    end
    chk("cr_no_bf", 32'(nbf), 0);
    m_idx = 0;
    foreach (m_fld[i]) m_fld[i] = 8'h00;
    do_resets(1'b0, 1'b1);
    do_byte(8'h11, 1'b1, 1'b1, lat, ff, f9, eff);
    chk("cr_after_ff", 32'(ff), 0);
    chk_model("cr_after");
    tick();

    do_resets(1'b1, 1'b1);
    foreach (seq[i]) seq[i] = 8'($urandom);
    k = 0;
    last = 0;
    nbf = 0;
    cmd_en = 1'b1;
    crc_en = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      byte_valid = k < 5;
      byte_in = seq[k % 5];
      #1;
      if (byte_valid && byte_ready) begin
        if (k > 0) chk($sformatf("cont_gap%0d", k), 32'(cyc - last), 10);
        last = cyc;
        void'(model_byte(seq[k], 1'b1, 1'b1));
        k++;
      end
      nbf += int'(byte_finished);
      tick();
    end
    byte_valid = 1'b0;
    chk("cont_accepts", 32'(k), 5);
    chk("cont_bf", 32'(nbf), 5);
    chk_model("cont");

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) tick();
      k = int'($urandom_range(0, 15));
      if (k == 0) do_resets(1'b1, 1'b0);
      else if (k == 1) do_resets(1'b0, 1'b1);
      else if (k == 2) do_resets(1'b1, 1'b1);
      b = 8'($urandom);
      ce = $urandom_range(0, 3) != 0;
      re = $urandom_range(0, 3) != 0;
      do_byte(b, ce, re, lat, ff, f9, eff);
      chk($sformatf("rnd%0d_lat", it), 32'(lat), 9);
      chk($sformatf("rnd%0d_ff", it), 32'(ff), 32'(eff));
      chk_model($sformatf("rnd%0d", it));
      tick();
    end

`ifdef CMD_FRAME_RX_TIMEOUT_EN
    do_resets(1'b1, 1'b1);
    do_byte(8'hAA, 1'b1, 1'b1, lat, ff, f9, eff);
    tick();
    k = 1;
    while (!to_p && k < 40) begin
      tick();
      k++;
    end
    chk("to_cycle", 32'(k), 16);
    m_idx = 0;
    m_c8 = 8'h00;
    m_c16 = 16'hFFFF;
    tick();
    for (int j = 0; j < 3; j++) begin
      do_byte(8'(8'h40 + j), 1'b1, 1'b1, lat, ff, f9, eff);
      chk($sformatf("to_ff%0d", j), 32'(ff), 32'(j == 2));
      chk_model($sformatf("to%0d", j));
      tick();
    end
    chk("to_cmd", 32'(cmd), 32'h40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
